// File: rtl/tx_arbiter.sv
// tx_arbiter: three-requester arbiter feeding one or two bytes per grant into a TX FIFO.
// Define TXA_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (0 > 1 > 2) otherwise.
module tx_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [2:0]                REQ_VLD,
    input  logic [3*2*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [2:0]                REQ_WIDE,
    input  logic                      FIFO_FULL,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic [2:0]                REQ_ACK,
    output logic [2:0]                GNT,
    output logic                      BUSY
);

    localparam int WW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SEND_LO,
        SEND_HI,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   hold_data;
    logic            hold_wide;
    logic [2:0]      gnt_q;
    logic [2:0]      pick;
    logic [WW-1:0]   pick_data;
    logic            pick_wide;

`ifdef TXA_ROUND_ROBIN_EN
    logic [1:0] last;

    // Round-robin winner: search starts one past the last granted requester
    always_comb begin
        pick = '0;
        case (last)
            2'd0: begin
                if (REQ_VLD[1])      pick = 3'b010;
                else if (REQ_VLD[2]) pick = 3'b100;
                else if (REQ_VLD[0]) pick = 3'b001;
            end
            2'd1: begin
                if (REQ_VLD[2])      pick = 3'b100;
                else if (REQ_VLD[0]) pick = 3'b001;
                else if (REQ_VLD[1]) pick = 3'b010;
            end
            default: begin
                if (REQ_VLD[0])      pick = 3'b001;
                else if (REQ_VLD[1]) pick = 3'b010;
                else if (REQ_VLD[2]) pick = 3'b100;
            end
        endcase
    end

    // Last-grant pointer advances when a transaction completes
    always_ff @(posedge CLK) begin
        if (RST) begin
            last <= 2'd2;
        end else if (state == DONE) begin
            if (gnt_q[1])      last <= 2'd1;
            else if (gnt_q[2]) last <= 2'd2;
            else               last <= 2'd0;
        end
    end
`else
    // Fixed priority winner: requester 0 highest
    always_comb begin
        pick = '0;
        if (REQ_VLD[0])      pick = 3'b001;
        else if (REQ_VLD[1]) pick = 3'b010;
        else if (REQ_VLD[2]) pick = 3'b100;
    end
`endif

    // Select the winner's word and width flag for latching
    always_comb begin
        pick_data = REQ_DATA[WW-1:0];
        pick_wide = REQ_WIDE[0];
        if (pick[1]) begin
            pick_data = REQ_DATA[2*WW-1:WW];
            pick_wide = REQ_WIDE[1];
        end else if (pick[2]) begin
            pick_data = REQ_DATA[3*WW-1:2*WW];
            pick_wide = REQ_WIDE[2];
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-state outputs
    always_comb begin
        state_nxt = state;
        TX_P_DATA = '0;
        TX_D_VLD  = 1'b0;
        REQ_ACK   = '0;
        case (state)
            IDLE: begin
                if (|REQ_VLD) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                TX_P_DATA = hold_data[DATA_WIDTH-1:0];
                TX_D_VLD  = !FIFO_FULL;
                if (!FIFO_FULL) state_nxt = hold_wide ? SEND_HI : DONE;
            end
            SEND_HI: begin
                TX_P_DATA = hold_data[WW-1:DATA_WIDTH];
                TX_D_VLD  = !FIFO_FULL;
                if (!FIFO_FULL) state_nxt = DONE;
            end
            DONE: begin
                REQ_ACK   = gnt_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding registers and grant: captured at arbitration, grant dropped after DONE
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_data <= '0;
            hold_wide <= 1'b0;
            gnt_q     <= '0;
        end else if (state == IDLE && (|REQ_VLD)) begin
            hold_data <= pick_data;
            hold_wide <= pick_wide;
            gnt_q     <= pick;
        end else if (state == DONE) begin
            gnt_q     <= '0;
        end
    end

    assign GNT  = gnt_q;
    assign BUSY = (state != IDLE);

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, TX byte width; request words are 2*DATA_WIDTH bits.
REQ-002 SHALL have ports:
- CLK  in  1  single clock (REF_CLK domain).
- RST  in  1  reset, synchronous, active-high.
- REQ_VLD  in  3  per-requester request, level; held high until REQ_ACK.
- REQ_DATA  in  3*2*DATA_WIDTH  packed words; requester i at bits [i*16+15 : i*16] for default width.
- REQ_WIDE  in  3  per requester: 1 = send two bytes (low, then high), 0 = low byte only.
- FIFO_FULL  in  1  TX FIFO full flag.
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO.
- TX_D_VLD  out  1  FIFO write strobe; one byte per high cycle.
- REQ_ACK  out  3  one-cycle pulse to the granted requester on completion.
- GNT  out  3  one-hot current grant; 0 when idle.
- BUSY  out  1  high whenever state is not IDLE.
REQ-003 SHALL use the single clock and a synchronous, active-high reset named as above.

Function
REQ-004 SHALL implement FSM states IDLE, SEND_LO, SEND_HI, DONE.
REQ-005 IDLE: if any REQ_VLD bit is high, SHALL pick a winner, latch its REQ_DATA word and REQ_WIDE bit into holding registers, set GNT, and go to SEND_LO; otherwise SHALL stay in IDLE.
REQ-006 SEND_LO: TX_D_VLD SHALL equal NOT FIFO_FULL, and TX_P_DATA SHALL be the latched low byte.
- Not full: go to SEND_HI if latched wide, else DONE.
- Full: hold state.
REQ-007 SEND_HI: same write rule with the latched high byte; not full: go to DONE.
REQ-008 DONE: SHALL pulse REQ_ACK[granted] for exactly one cycle, update the arbitration pointer, clear GNT on exit, and return to IDLE; TX_D_VLD SHALL be 0.
REQ-009 TX_D_VLD SHALL never be high in IDLE or DONE, or while FIFO_FULL is high.
REQ-010 Latency, FIFO never full, REQ_VLD seen in IDLE at cycle n:
- Low byte written at n+1.
- Narrow: ACK at n+2.
- Wide: high byte at n+2, ACK at n+3.
REQ-011 Each FIFO_FULL cycle in SEND_LO or SEND_HI SHALL add exactly one cycle of stall; bytes are never dropped or duplicated.
REQ-012 REQ_DATA, REQ_WIDE and REQ_VLD changes after grant SHALL NOT affect the transaction in flight; there is no abort.
REQ-013 A requester that drops REQ_VLD in the cycle after REQ_ACK SHALL NOT be re-granted.
REQ-014 Minimum gap between grants SHALL be one IDLE cycle; back-to-back narrow requests SHALL therefore complete every 3 cycles.
REQ-015 Non-granted requesters SHALL be ignored until the next IDLE arbitration.

Reset
REQ-016 RST high at a clock edge SHALL force IDLE from any state, including mid-transaction; the in-flight transaction is discarded with no ACK.
REQ-017 Under reset SHALL hold TX_P_DATA=0, TX_D_VLD=0, REQ_ACK=0, GNT=0, BUSY=0, holding registers=0, and last-grant pointer=2 (so requester 0 wins first).

Configuration
REQ-018 Macro TXA_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: round-robin; search starts at (last grant + 1) mod 3; pointer updates in DONE.
- Undefined: fixed priority, requester 0 highest, then 1, then 2; pointer unused.

Verification
REQ-019 Narrow request: REQ_VLD=001, data 0x12A5, wide=0, FIFO not full -> single TX_D_VLD with 0xA5 at n+1, REQ_ACK=001 at n+2, GNT=001 during n+1..n+2.
REQ-020 Wide request with stall: REQ_VLD=010, data 0xBEEF, wide=1, FIFO_FULL high for 2 cycles after the low byte -> writes 0xEF, then 0xBE exactly 2 cycles late, REQ_ACK=010 once.
REQ-021 All three requesting continuously, narrow, 6 grants:
- With TXA_ROUND_ROBIN_EN: order 0,1,2,0,1,2.
- Without: order 0,0,0... while REQ_VLD[0] stays high.
REQ-022 RST asserted while in SEND_HI -> next cycle IDLE with all outputs 0, no REQ_ACK, no further TX_D_VLD.
REQ-023 REQ_DATA changed from 0x1111 to 0x2222 the cycle after grant -> the FIFO receives 0x11 (and 0x11 if wide), not 0x22.
REQ-024 REQ_VLD=000 for 10 cycles -> BUSY, GNT, TX_D_VLD and REQ_ACK stay 0 throughout.
